// File: rtl/alex_spi_receiver.sv
// Alex serial control link deserialiser: synchronises data/clock/strobe, shifts MSB first,
// validates frame length at the strobe and optionally requires two identical frames.
module alex_spi_receiver #(
  parameter int WORD_BITS = 32,
  parameter int REPEAT    = 1,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 spi_clock,
  input  logic                 reset,
  input  logic                 SPI_data_in,
  input  logic                 SPI_clock_in,
  input  logic                 Rx_load_strobe_in,
  output logic [WORD_BITS-1:0] Alex_data_out,
  output logic                 word_valid,
  output logic                 frame_error
);

  localparam int CW = $clog2(WORD_BITS + 2);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  state_t               state, state_nx;
  logic [2:0]           data_sr, clk_sr, stb_sr;
  logic                 clk_edge, stb_edge, data_bit;
  logic [CW-1:0]        count, count_nx, count_inc;
  logic [TW-1:0]        tmo, tmo_nx;
  logic [WORD_BITS-1:0] shift, shift_nx, shifted;
  logic [WORD_BITS-1:0] cand, cand_nx, out_nx;
  logic                 cand_valid, cand_valid_nx, wv_nx, fe_nx;

  // [0],[1] synchroniser, [2] history; edge and data bit registered together so they stay aligned
  always_ff @(posedge spi_clock) begin
    if (reset) begin
      data_sr  <= '0;
      clk_sr   <= '0;
      stb_sr   <= '0;
      clk_edge <= 1'b0;
      stb_edge <= 1'b0;
      data_bit <= 1'b0;
    end else begin
      data_sr  <= {data_sr[1:0], SPI_data_in};
      clk_sr   <= {clk_sr[1:0], SPI_clock_in};
      stb_sr   <= {stb_sr[1:0], Rx_load_strobe_in};
      clk_edge <= clk_sr[1] & ~clk_sr[2];
      stb_edge <= stb_sr[1] & ~stb_sr[2];
      data_bit <= data_sr[1];
    end
  end

  assign shifted   = {shift[WORD_BITS-2:0], data_bit};
  assign count_inc = (count == CW'(WORD_BITS + 1)) ? count : count + 1'b1;

  always_ff @(posedge spi_clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    count_nx      = count;
    shift_nx      = shift;
    tmo_nx        = tmo;
    out_nx        = Alex_data_out;
    cand_nx       = cand;
    cand_valid_nx = cand_valid;
    wv_nx         = 1'b0;
    fe_nx         = 1'b0;
    case (state)
      IDLE: begin
        tmo_nx = '0;
        if (clk_edge) begin
          shift_nx = shifted;
          count_nx = CW'(1);
          state_nx = stb_edge ? CHECK : SHIFT;
        end else if (stb_edge) begin
          fe_nx = 1'b1;
        end
      end
      SHIFT: begin
        if (clk_edge) begin
          shift_nx = shifted;
          count_nx = count_inc;
          tmo_nx   = '0;
        end
        if (stb_edge) begin
          state_nx = CHECK;
          tmo_nx   = '0;
        end else if (!clk_edge) begin
          if (tmo == TW'(TIMEOUT - 1)) begin
            fe_nx    = 1'b1;
            count_nx = '0;
            tmo_nx   = '0;
            state_nx = IDLE;
          end else begin
            tmo_nx = tmo + 1'b1;
          end
        end
      end
      CHECK: begin
        if (count != CW'(WORD_BITS)) begin
          fe_nx = 1'b1;
        end else if (REPEAT == 0) begin
          out_nx = shift;
          wv_nx  = 1'b1;
        end else if (cand_valid && shift == cand) begin
          out_nx        = shift;
          wv_nx         = 1'b1;
          cand_valid_nx = 1'b0;
        end else begin
          cand_nx       = shift;
          cand_valid_nx = 1'b1;
        end
        tmo_nx   = '0;
        count_nx = '0;
        state_nx = IDLE;
        // a serial-clock edge during CHECK starts the next frame
        if (clk_edge) begin
          shift_nx = shifted;
          count_nx = CW'(1);
          state_nx = SHIFT;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge spi_clock) begin
    if (reset) begin
      count         <= '0;
      tmo           <= '0;
      shift         <= '0;
      cand          <= '0;
      cand_valid    <= 1'b0;
      Alex_data_out <= '0;
      word_valid    <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      count         <= count_nx;
      tmo           <= tmo_nx;
      shift         <= shift_nx;
      cand          <= cand_nx;
      cand_valid    <= cand_valid_nx;
      Alex_data_out <= out_nx;
      word_valid    <= wv_nx;
      frame_error   <= fe_nx;
    end
  end

endmodule

// File: tb/tb_alex_spi_receiver.sv
// Directed bench for alex_spi_receiver: a REPEAT=1 instance and a REPEAT=0 instance
// share the serial lines; pulses are counted on the falling clock edge.
module tb_alex_spi_receiver;

  logic        spi_clock = 1'b0;
  logic        reset = 1'b1;
  logic        SPI_data_in = 1'b0;
  logic        SPI_clock_in = 1'b0;
  logic        Rx_load_strobe_in = 1'b0;
  logic [31:0] Alex_data_out, Alex_data_out0;
  logic        word_valid, frame_error, word_valid0, frame_error0;

  int checks = 0;
  int failures = 0;
  int wv_cnt = 0, fe_cnt = 0, wv0_cnt = 0, fe0_cnt = 0, both_cnt = 0;

  always #5 spi_clock = ~spi_clock;

  alex_spi_receiver #(.WORD_BITS(32), .REPEAT(1), .TIMEOUT(1024)) dut (
    .spi_clock(spi_clock), .reset(reset), .SPI_data_in(SPI_data_in),
    .SPI_clock_in(SPI_clock_in), .Rx_load_strobe_in(Rx_load_strobe_in),
    .Alex_data_out(Alex_data_out), .word_valid(word_valid), .frame_error(frame_error));

  alex_spi_receiver #(.WORD_BITS(32), .REPEAT(0), .TIMEOUT(1024)) dut0 (
    .spi_clock(spi_clock), .reset(reset), .SPI_data_in(SPI_data_in),
    .SPI_clock_in(SPI_clock_in), .Rx_load_strobe_in(Rx_load_strobe_in),
    .Alex_data_out(Alex_data_out0), .word_valid(word_valid0), .frame_error(frame_error0));

  always @(negedge spi_clock) begin
    if (word_valid)  wv_cnt++;
    if (frame_error) fe_cnt++;
    if (word_valid0)  wv0_cnt++;
    if (frame_error0) fe0_cnt++;
    if ((word_valid && frame_error) || (word_valid0 && frame_error0)) both_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge spi_clock);
    #1;
  endtask

  task automatic send_bit(input logic b);
    SPI_data_in = b;
    tick(3);
    SPI_clock_in = 1'b1;
    tick(3);
    SPI_clock_in = 1'b0;
  endtask

  task automatic send_bits(input logic [63:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic strobe();
    tick(3);
    Rx_load_strobe_in = 1'b1;
    tick(3);
    Rx_load_strobe_in = 1'b0;
    tick(6);
  endtask

  task automatic send_frame(input logic [31:0] w);
    send_bits({32'h0, w}, 32);
    strobe();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(4);
    checks++; if (Alex_data_out !== 32'h0) begin $display("FAIL reset_data got=%h exp=%h", Alex_data_out, 32'h0); failures++; end
    checks++; if (word_valid !== 1'b0) begin $display("FAIL reset_wv got=%b exp=0", word_valid); failures++; end
    checks++; if (frame_error !== 1'b0) begin $display("FAIL reset_fe got=%b exp=0", frame_error); failures++; end
    reset = 1'b0;
    tick(4);
  endtask

  task automatic test_repeat_pair();
    int wv_b, fe_b, wv0_b;
    wv_b = wv_cnt; fe_b = fe_cnt; wv0_b = wv0_cnt;
    send_frame(32'hA5A50F0F);
    checks++; if (wv_cnt - wv_b !== 0) begin $display("FAIL pair_first_wv got=%0d exp=0", wv_cnt - wv_b); failures++; end
    checks++; if (Alex_data_out !== 32'h0) begin $display("FAIL pair_first_data got=%h exp=%h", Alex_data_out, 32'h0); failures++; end
    checks++; if (Alex_data_out0 !== 32'hA5A50F0F) begin $display("FAIL pair_norepeat_data got=%h exp=%h", Alex_data_out0, 32'hA5A50F0F); failures++; end
    send_frame(32'hA5A50F0F);
    checks++; if (wv_cnt - wv_b !== 1) begin $display("FAIL pair_second_wv got=%0d exp=1", wv_cnt - wv_b); failures++; end
    checks++; if (Alex_data_out !== 32'hA5A50F0F) begin $display("FAIL pair_second_data got=%h exp=%h", Alex_data_out, 32'hA5A50F0F); failures++; end
    checks++; if (fe_cnt - fe_b !== 0) begin $display("FAIL pair_fe got=%0d exp=0", fe_cnt - fe_b); failures++; end
    checks++; if (wv0_cnt - wv0_b !== 2) begin $display("FAIL pair_norepeat_wv got=%0d exp=2", wv0_cnt - wv0_b); failures++; end
  endtask

  task automatic test_mismatch();
    int wv_b;
    wv_b = wv_cnt;
    send_frame(32'h00000001);
    send_frame(32'h00000002);
    checks++; if (wv_cnt - wv_b !== 0) begin $display("FAIL mismatch_wv got=%0d exp=0", wv_cnt - wv_b); failures++; end
    checks++; if (Alex_data_out !== 32'hA5A50F0F) begin $display("FAIL mismatch_hold got=%h exp=%h", Alex_data_out, 32'hA5A50F0F); failures++; end
    send_frame(32'h00000002);
    checks++; if (wv_cnt - wv_b !== 1) begin $display("FAIL mismatch_match_wv got=%0d exp=1", wv_cnt - wv_b); failures++; end
    checks++; if (Alex_data_out !== 32'h00000002) begin $display("FAIL mismatch_data got=%h exp=%h", Alex_data_out, 32'h2); failures++; end
  endtask

  task automatic test_bad_length();
    int fe_b, wv_b;
    fe_b = fe_cnt; wv_b = wv_cnt;
    send_bits(64'h7FFF_FFFF, 31);
    strobe();
    checks++; if (fe_cnt - fe_b !== 1) begin $display("FAIL short_fe got=%0d exp=1", fe_cnt - fe_b); failures++; end
    checks++; if (Alex_data_out !== 32'h00000002) begin $display("FAIL short_hold got=%h exp=%h", Alex_data_out, 32'h2); failures++; end
    send_bits({31'h0, 1'b1, 32'h00000002}, 33);
    strobe();
    checks++; if (fe_cnt - fe_b !== 2) begin $display("FAIL long_fe got=%0d exp=2", fe_cnt - fe_b); failures++; end
    strobe();
    checks++; if (fe_cnt - fe_b !== 3) begin $display("FAIL empty_fe got=%0d exp=3", fe_cnt - fe_b); failures++; end
    checks++; if (wv_cnt - wv_b !== 0) begin $display("FAIL badlen_wv got=%0d exp=0", wv_cnt - wv_b); failures++; end
    checks++; if (Alex_data_out !== 32'h00000002) begin $display("FAIL badlen_hold got=%h exp=%h", Alex_data_out, 32'h2); failures++; end
  endtask

  task automatic test_timeout();
    int fe_b, wv_b;
    fe_b = fe_cnt; wv_b = wv_cnt;
    send_bits(64'h2AA, 10);
    tick(1000);
    checks++; if (fe_cnt - fe_b !== 0) begin $display("FAIL timeout_early got=%0d exp=0", fe_cnt - fe_b); failures++; end
    tick(1024 + 10 - 1000);
    checks++; if (fe_cnt - fe_b !== 1) begin $display("FAIL timeout_fe got=%0d exp=1", fe_cnt - fe_b); failures++; end
    send_frame(32'h3C3C5A5A);
    send_frame(32'h3C3C5A5A);
    checks++; if (Alex_data_out !== 32'h3C3C5A5A) begin $display("FAIL timeout_recover got=%h exp=%h", Alex_data_out, 32'h3C3C5A5A); failures++; end
    checks++; if (wv_cnt - wv_b !== 1) begin $display("FAIL timeout_recover_wv got=%0d exp=1", wv_cnt - wv_b); failures++; end
  endtask

  task automatic test_reset_midframe();
    int fe_b, wv_b;
    fe_b = fe_cnt; wv_b = wv_cnt;
    send_bits({32'h0, 32'hDEADBEEF} >> 16, 16);
    reset = 1'b1;
    tick(1);
    @(negedge spi_clock);
    checks++; if (Alex_data_out !== 32'h0) begin $display("FAIL midreset_data got=%h exp=%h", Alex_data_out, 32'h0); failures++; end
    checks++; if (word_valid !== 1'b0 || frame_error !== 1'b0) begin $display("FAIL midreset_pulses got=%b%b exp=00", word_valid, frame_error); failures++; end
    tick(2);
    reset = 1'b0;
    tick(4);
    send_frame(32'hDEADBEEF);
    send_frame(32'hDEADBEEF);
    checks++; if (fe_cnt - fe_b !== 0) begin $display("FAIL midreset_fe got=%0d exp=0", fe_cnt - fe_b); failures++; end
    checks++; if (Alex_data_out !== 32'hDEADBEEF) begin $display("FAIL midreset_final got=%h exp=%h", Alex_data_out, 32'hDEADBEEF); failures++; end
    checks++; if (wv_cnt - wv_b !== 1) begin $display("FAIL midreset_wv got=%0d exp=1", wv_cnt - wv_b); failures++; end
  endtask

  task automatic test_no_repeat_latency();
    logic wv_at4, wv_at5;
    int wv_b;
    wv_b = wv_cnt;
    send_bits({32'h0, 32'h12345678}, 32);
    tick(3);
    Rx_load_strobe_in = 1'b1;
    wv_at4 = 1'b0; wv_at5 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge spi_clock);
      @(negedge spi_clock);
      if (k == 4) wv_at4 = word_valid0;
      if (k == 5) wv_at5 = word_valid0;
    end
    Rx_load_strobe_in = 1'b0;
    tick(6);
    checks++; if (wv_at4 !== 1'b0) begin $display("FAIL latency_early got=%b exp=0", wv_at4); failures++; end
    checks++; if (wv_at5 !== 1'b1) begin $display("FAIL latency_wv got=%b exp=1", wv_at5); failures++; end
    checks++; if (Alex_data_out0 !== 32'h12345678) begin $display("FAIL norepeat_data got=%h exp=%h", Alex_data_out0, 32'h12345678); failures++; end
    checks++; if (Alex_data_out !== 32'hDEADBEEF) begin $display("FAIL repeat_single_hold got=%h exp=%h", Alex_data_out, 32'hDEADBEEF); failures++; end
    checks++; if (wv_cnt - wv_b !== 0) begin $display("FAIL repeat_single_wv got=%0d exp=0", wv_cnt - wv_b); failures++; end
  endtask

  initial begin
    test_reset();
    test_repeat_pair();
    test_mismatch();
    test_bad_length();
    test_timeout();
    test_reset_midframe();
    test_no_repeat_latency();
    checks++; if (both_cnt !== 0) begin $display("FAIL exclusive_pulses got=%0d exp=0", both_cnt); failures++; end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alex_spi_receiver.md
Name: alex_spi_receiver

Overview:
- Far end of the Alex serial control link: the deserialiser that takes the 3-wire stream (data, clock, load strobe) from the Alex SPI transmitter and recovers the 32-bit control word.
- Samples the incoming lines with a local clock, shifts bits in MSB first and validates frame length at the load strobe.
- Optionally requires the word to arrive twice identically, matching the transmitter's send-twice behaviour, before updating the relay/filter control output.
- Used in loopback test benches and on the Alex-side FPGA.

Parameters:
- WORD_BITS, 32, bits per frame; sets the expected bit count and the width of the shift register and output.
- REPEAT, 1, 1 = output updates only after two consecutive identical valid frames; 0 = every valid frame updates the output.
- TIMEOUT, 1024, local clock cycles with no serial-clock rising edge, mid-frame, before the partial frame is discarded.

Ports:
- spi_clock  in  1  local sampling clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- SPI_data_in  in  1  serial data, asynchronous to spi_clock.
- SPI_clock_in  in  1  serial clock, asynchronous; data is valid at its rising edge.
- Rx_load_strobe_in  in  1  load strobe, asynchronous; its rising edge ends a frame.
- Alex_data_out  out  WORD_BITS  last accepted control word.
- word_valid  out  1  one-cycle pulse when Alex_data_out is updated.
- frame_error  out  1  one-cycle pulse when a frame is discarded (bad length or timeout).

Behaviour:
- Reset values: Alex_data_out=0, word_valid=0, frame_error=0. Reset also clears the shift register, bit count, candidate word, timeout counter and all synchroniser flops, and returns the FSM to IDLE. Reset mid-frame discards the partial frame with no error pulse.
- Synchronisation:
  - Each of the three inputs passes a 2-flop synchroniser, then a third history flop.
  - Edge = synchronised value high and history value low.
  - Edge-detect latency is 3 spi_clock cycles from the input transition.
  - Each serial input phase must be held for at least 2 spi_clock cycles; shorter pulses may be missed. This is not checked.
- FSM:
  - IDLE: bit count 0. A serial-clock edge shifts in a bit (count becomes 1) and moves to SHIFT. A strobe edge in IDLE counts as a frame with 0 bits: frame_error, stay in IDLE.
  - SHIFT:
    - Each serial-clock edge does shift = {shift[WORD_BITS-2:0], data_sync} and increments the count.
    - The count saturates at WORD_BITS+1, marking overflow.
    - The timeout counter clears on each edge.
    - A strobe edge moves to CHECK.
    - If the timeout counter reaches TIMEOUT-1 with no edge: frame_error, go to IDLE.
  - CHECK (1 cycle):
    - Count != WORD_BITS: frame_error.
    - Else, REPEAT=0: Alex_data_out <= shift, word_valid.
    - Else, REPEAT=1, candidate valid and shift == candidate: Alex_data_out <= shift, word_valid, candidate invalidated.
    - Else, REPEAT=1: candidate <= shift, candidate marked valid, no pulse.
    - In all cases clear the count and go to IDLE.
- Simultaneous serial-clock edge and strobe edge in SHIFT: the bit is shifted and counted first; CHECK uses the updated count.
- A serial-clock edge that arrives while in CHECK is taken as the first bit of the next frame (count=1, next state SHIFT).
- A frame_error leaves the candidate unchanged. This lets a retransmission pair still complete if the error lands between the two copies.
- Latency: word_valid and the new Alex_data_out appear together in the cycle after CHECK, 5 spi_clock cycles after the strobe's input rising edge. Alex_data_out holds its value otherwise.
- word_valid and frame_error are never high in the same cycle.

Test Plan:
- REPEAT=1: send 0xA5A50F0F twice, 32 bits each, strobe after each → no pulse after the first strobe; after the second, Alex_data_out=0xA5A50F0F with a single word_valid.
- REPEAT=1: send 0x00000001 then 0x00000002, then 0x00000002 again → no update after the first two; after the third, Alex_data_out=0x00000002.
- Send 31 bits then strobe → one frame_error, Alex_data_out unchanged. Send 33 bits then strobe → one frame_error.
- Send 10 bits, then hold the serial clock idle for TIMEOUT+10 cycles → frame_error once near TIMEOUT; a full 32-bit pair afterwards decodes correctly.
- Assert reset after bit 16 of a frame, then send a full pair 0xDEADBEEF → all outputs 0 during reset, no error pulse, final Alex_data_out=0xDEADBEEF.
- REPEAT=0: single frame 0x12345678 → word_valid 5 cycles after the strobe edge, Alex_data_out=0x12345678.
